// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing a single-ported 1024x32 data RAM between the CPU LSU (port 0) and the debug loader (port 1).
// Define RAM_ARB_RR_EN for round-robin arbitration in OPEN; otherwise port 0 has fixed priority.
module ram_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        state_reg;
    logic          grant0;
    logic          grant1;
    logic [AW-1:0] addr_hold_reg;
    logic [DW-1:0] din_hold_reg;

    // Per-port views so the read-return path can be generated per requester.
    logic          grant_v  [2];
    logic          we_v     [2];
    logic          rvalid_v [2];
    logic [DW-1:0] rdata_v  [2];

`ifdef RAM_ARB_RR_EN
    logic ptr_reg;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_reg)
            LOCK0: grant0 = req0;
            LOCK1: grant1 = req1;
            default: begin
                if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
                    grant0 = ~ptr_reg;
                    grant1 = ptr_reg;
`else
                    grant0 = 1'b1;
`endif
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end
            end
        endcase
    end

    assign ack0 = grant0;
    assign ack1 = grant1;

    // Idle cycles replay the last granted address/data so the RAM pins stay quiet.
    always_comb begin
        ram_addr = addr_hold_reg;
        ram_din  = din_hold_reg;
        ram_we   = 1'b0;
        if (grant0) begin
            ram_addr = addr0;
            ram_din  = wdata0;
            ram_we   = we0;
        end else if (grant1) begin
            ram_addr = addr1;
            ram_din  = wdata1;
            ram_we   = we1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= OPEN;
            addr_hold_reg <= '0;
            din_hold_reg  <= '0;
`ifdef RAM_ARB_RR_EN
            ptr_reg       <= 1'b0;
`endif
        end else begin
            if (grant0 || grant1) begin
                addr_hold_reg <= ram_addr;
                din_hold_reg  <= ram_din;
`ifdef RAM_ARB_RR_EN
                ptr_reg       <= grant0;
`endif
            end
            case (state_reg)
                OPEN: begin
                    if (grant0 && lock0)
                        state_reg <= LOCK0;
                    else if (grant1 && lock1)
                        state_reg <= LOCK1;
                end
                LOCK0: begin
                    // Holder either finishes with lock cleared or walks away.
                    if (!req0 || (grant0 && !lock0))
                        state_reg <= OPEN;
                end
                LOCK1: begin
                    if (!req1 || (grant1 && !lock1))
                        state_reg <= OPEN;
                end
                default: state_reg <= OPEN;
            endcase
        end
    end

    assign grant_v[0] = grant0;
    assign grant_v[1] = grant1;
    assign we_v[0]    = we0;
    assign we_v[1]    = we1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_v[gi] <= 1'b0;
                    rdata_v[gi]  <= '0;
                end else begin
                    rvalid_v[gi] <= grant_v[gi] && !we_v[gi];
                    if (grant_v[gi] && !we_v[gi])
                        rdata_v[gi] <= ram_dout;
                end
            end
        end
    endgenerate

    assign rvalid0 = rvalid_v[0];
    assign rvalid1 = rvalid_v[1];
    assign rdata0  = rdata_v[0];
    assign rdata1  = rdata_v[1];

endmodule
